// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and constants for the forwarding / load-use hazard controller.
// Tag layout, select encodings and the forwarding priority function live here.
package fwd_hazard_ctrl_pkg;

  localparam int TAG_AW = 5;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] rd;
    logic              mem_read;
  } tag_t;

  localparam tag_t TAG_INVALID = '{valid: 1'b0, rd: '0, mem_read: 1'b0};

  // Newest producer wins; register 0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [TAG_AW-1:0] src,
                                         input tag_t t_ex,
                                         input tag_t t_mem);
    logic [1:0] sel;
    sel = FWD_REG;
    if (src != '0 && t_ex.valid && t_ex.rd == src) begin
      sel = FWD_MEM;
    end else if (src != '0 && t_mem.valid && t_mem.rd == src) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_tag_stage.sv
// One in-flight destination tag register: synchronous reset, load enable,
// and clear-to-bubble (clear has priority over load data).
module fwd_tag_stage
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic clear_i,
  input  tag_t d_i,
  output tag_t q_o
);

  tag_t tag_q;
  tag_t tag_d;

  always_comb begin
    tag_d = tag_q;
    if (clear_i) begin
      tag_d = TAG_INVALID;
    end else if (load_i) begin
      tag_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q <= TAG_INVALID;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign q_o = tag_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall generation for the 5-stage pipeline.
// Optional statistics counters are built when FWD_HAZARD_CTRL_STATS_EN is defined.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              stall_o
`ifdef FWD_HAZARD_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  fwd_cnt_o
`endif
);

  if (REG_AW > TAG_AW) begin : g_aw_check
    $error("REG_AW exceeds tag address width");
  end

  tag_t t_ex, t_mem, t_wb, ex_d;
  logic [TAG_AW-1:0] src_a, src_b;
  logic hazard, bubble;
  logic [1:0] sel_a_d, sel_a_q, sel_b_d, sel_b_q;

  always_comb begin
    src_a = TAG_AW'(id_rs_i);
    src_b = id_use_rt_i ? TAG_AW'(id_rt_i) : '0;
    ex_d  = '{valid:    id_reg_write_i & (id_rd_i != '0),
              rd:       TAG_AW'(id_rd_i),
              mem_read: id_mem_read_i};
  end

  assign hazard = t_ex.valid & t_ex.mem_read & id_valid_i &
                  ((src_a == t_ex.rd) | (id_use_rt_i & (src_b == t_ex.rd)));
  assign stall_o = hazard & ~flush_i;
  assign bubble  = flush_i | stall_o | ~id_valid_i;

  always_comb begin
    sel_a_d = FWD_REG;
    sel_b_d = FWD_REG;
    if (!bubble) begin
      sel_a_d = fwd_sel(src_a, t_ex, t_mem);
      sel_b_d = fwd_sel(src_b, t_ex, t_mem);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_a_q <= FWD_REG;
      sel_b_q <= FWD_REG;
    end else begin
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign fwd_a_sel_o = sel_a_q;
  assign fwd_b_sel_o = sel_b_q;

  // EX and later stages never stall, so MEM and WB shift every edge.
  fwd_tag_stage u_ex (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (1'b1),
    .clear_i (bubble),
    .d_i     (ex_d),
    .q_o     (t_ex)
  );

  fwd_tag_stage u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (1'b1),
    .clear_i (1'b0),
    .d_i     (t_ex),
    .q_o     (t_mem)
  );

  fwd_tag_stage u_wb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (1'b1),
    .clear_i (1'b0),
    .d_i     (t_mem),
    .q_o     (t_wb)
  );

  // The WB tag is tracked for pipeline symmetry; the register file handles WB reads.
  logic unused_wb;
  assign unused_wb = ^t_wb;

`ifdef FWD_HAZARD_CTRL_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W:0]   stall_sum, fwd_sum;
  logic [1:0]       fwd_inc;

  always_comb begin
    fwd_inc     = {1'b0, sel_a_d != FWD_REG} + {1'b0, sel_b_d != FWD_REG};
    stall_sum   = {1'b0, stall_cnt_q} + (CNT_W+1)'(stall_o);
    fwd_sum     = {1'b0, fwd_cnt_q} + (CNT_W+1)'(fwd_inc);
    stall_cnt_d = stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
    fwd_cnt_d   = fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign fwd_cnt_o   = fwd_cnt_q;
`else
  if (CNT_W < 1) begin : g_cnt_check
    $error("CNT_W must be at least 1");
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; counter checks are added when
// FWD_HAZARD_CTRL_STATS_EN is defined.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_use_rt = 1'b0, id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef FWD_HAZARD_CTRL_STATS_EN
  logic [15:0] stall_cnt, fwd_cnt;
  logic [3:0]  sat_stall_cnt, sat_fwd_cnt;
  logic [1:0]  sat_a_sel, sat_b_sel;
  logic        sat_stall;
`endif

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_use_rt_i    (id_use_rt),
    .id_rd_i        (id_rd),
    .id_reg_write_i (id_reg_write),
    .id_mem_read_i  (id_mem_read),
    .flush_i        (flush),
    .fwd_a_sel_o    (fwd_a_sel),
    .fwd_b_sel_o    (fwd_b_sel),
    .stall_o        (stall)
`ifdef FWD_HAZARD_CTRL_STATS_EN
    ,
    .stall_cnt_o    (stall_cnt),
    .fwd_cnt_o      (fwd_cnt)
`endif
  );

`ifdef FWD_HAZARD_CTRL_STATS_EN
  // Narrow-counter copy so saturation is reachable in a short run.
  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut_sat (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_use_rt_i    (id_use_rt),
    .id_rd_i        (id_rd),
    .id_reg_write_i (id_reg_write),
    .id_mem_read_i  (id_mem_read),
    .flush_i        (flush),
    .fwd_a_sel_o    (sat_a_sel),
    .fwd_b_sel_o    (sat_b_sel),
    .stall_o        (sat_stall),
    .stall_cnt_o    (sat_stall_cnt),
    .fwd_cnt_o      (sat_fwd_cnt)
  );
`endif

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic use_rt, input logic [4:0] rd,
                       input logic rw, input logic mr);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_use_rt    = use_rt;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = 1'b0;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  // Scenarios.
  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    tests_run++;
    if (fwd_a_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_sel_a: got %0d expected 0", fwd_a_sel);
    end
    tests_run++;
    if (fwd_b_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_sel_b: got %0d expected 0", fwd_b_sel);
    end
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_stall: got %0b expected 0", stall);
    end
    rst = 1'b0;
  endtask

  task automatic test_fwd_ex();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);  // add $3,$1,$2
    step();
    drive(1'b1, 5'd3, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0);  // sub $6,$3,$4
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_ex_stall: got %0b expected 0", stall);
    end
    step();
    idle();
    tests_run++;
    if (fwd_a_sel !== 2'd1) begin
      tests_failed++;
      $display("FAIL fwd_ex_a: got %0d expected 1", fwd_a_sel);
    end
    tests_run++;
    if (fwd_b_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL fwd_ex_b: got %0d expected 0", fwd_b_sel);
    end
  endtask

  task automatic test_fwd_wb();
    do_reset();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);  // add $3
    step();
    idle();                                           // nop
    step();
    drive(1'b1, 5'd1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0);  // or $7,$1,$3
    step();
    idle();
    tests_run++;
    if (fwd_a_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL fwd_wb_a: got %0d expected 0", fwd_a_sel);
    end
    tests_run++;
    if (fwd_b_sel !== 2'd2) begin
      tests_failed++;
      $display("FAIL fwd_wb_b: got %0d expected 2", fwd_b_sel);
    end
    // A producer three instructions back is read from the register file.
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);  // addi $9
    step();
    idle();
    step();
    step();
    drive(1'b1, 5'd9, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    step();
    idle();
    tests_run++;
    if (fwd_a_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL fwd_old_a: got %0d expected 0", fwd_a_sel);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);  // lw $5
    step();
    drive(1'b1, 5'd5, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);  // add $6,$5,$0
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_use_stall: got %0b expected 1", stall);
    end
    step();
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_use_stall_clear: got %0b expected 0", stall);
    end
    tests_run++;
    if (fwd_a_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL load_use_bubble_a: got %0d expected 0", fwd_a_sel);
    end
    step();
    idle();
    tests_run++;
    if (fwd_a_sel !== 2'd2) begin
      tests_failed++;
      $display("FAIL load_use_a: got %0d expected 2", fwd_a_sel);
    end
    tests_run++;
    if (fwd_b_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL load_use_b: got %0d expected 0", fwd_b_sel);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);  // addi $4
    step();
    drive(1'b1, 5'd2, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);  // addi $4
    step();
    drive(1'b1, 5'd8, 5'd4, 1'b1, 5'd11, 1'b1, 1'b0); // add $11,$8,$4
    step();
    tests_run++;
    if (fwd_b_sel !== 2'd1) begin
      tests_failed++;
      $display("FAIL newest_wins_b: got %0d expected 1", fwd_b_sel);
    end
    do_reset();
    drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);  // write to $0
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0);
    step();
    idle();
    tests_run++;
    if (fwd_a_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL zero_reg_a: got %0d expected 0", fwd_a_sel);
    end
    tests_run++;
    if (fwd_b_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL zero_reg_b: got %0d expected 0", fwd_b_sel);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);  // lw $7
    step();
    drive(1'b1, 5'd7, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0);  // add $8,$7,$1
    flush = 1'b1;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_stall: got %0b expected 0", stall);
    end
    step();
    drive(1'b1, 5'd8, 5'd7, 1'b1, 5'd9, 1'b1, 1'b0);  // reader of $8 and $7
    tests_run++;
    if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL flush_bubble_sel: got a=%0d b=%0d expected a=0 b=0", fwd_a_sel, fwd_b_sel);
    end
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_next_stall: got %0b expected 0", stall);
    end
    step();
    idle();
    tests_run++;
    if (fwd_a_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL flush_squashed_a: got %0d expected 0", fwd_a_sel);
    end
    tests_run++;
    if (fwd_b_sel !== 2'd2) begin
      tests_failed++;
      $display("FAIL flush_load_b: got %0d expected 2", fwd_b_sel);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);  // lw $3
    step();
    rst = 1'b1;
    drive(1'b1, 5'd3, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
    step();
    rst = 1'b0;
    #1;
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_stall: got %0b expected 0", stall);
    end
    step();
    idle();
    tests_run++;
    if (fwd_a_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_a: got %0d expected 0", fwd_a_sel);
    end
    tests_run++;
    if (fwd_b_sel !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_b: got %0d expected 0", fwd_b_sel);
    end
  endtask

`ifdef FWD_HAZARD_CTRL_STATS_EN
  task automatic test_stats();
    do_reset();
    tests_run++;
    if (stall_cnt !== 16'd0 || fwd_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL stats_reset: got stall=%0d fwd=%0d expected 0 0", stall_cnt, fwd_cnt);
    end
    // lw $5,0($5) held in ID: alternates stall / load-with-select-2.
    drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    for (int i = 0; i < 41; i++) step();
    idle();
    tests_run++;
    if (stall_cnt !== 16'd20) begin
      tests_failed++;
      $display("FAIL stats_stall_cnt: got %0d expected 20", stall_cnt);
    end
    tests_run++;
    if (fwd_cnt !== 16'd20) begin
      tests_failed++;
      $display("FAIL stats_fwd_cnt: got %0d expected 20", fwd_cnt);
    end
    tests_run++;
    if (sat_stall_cnt !== 4'hF || sat_fwd_cnt !== 4'hF) begin
      tests_failed++;
      $display("FAIL stats_saturate: got stall=%0d fwd=%0d expected 15 15", sat_stall_cnt, sat_fwd_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_wb();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_mid_reset();
`ifdef FWD_HAZARD_CTRL_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and load-use hazard controller for the 5-stage pipelined CPU. It keeps its own pipeline of in-flight destination tags for EX, MEM and WB. From these tags it produces registered select codes for the two 3-to-1 ALU-operand forwarding muxes in EX, and a combinational stall for load-use hazards. It sits beside the ID/EX pipeline register and moves its tags in lockstep with the datapath.

## Interface
Parameters:
- REG_AW, 5, register-address width
- CNT_W, 16, statistics counter width (used only with FWD_HAZARD_CTRL_STATS_EN)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- id_valid_i  in  1  ID stage holds a real instruction
- id_rs_i  in  REG_AW  ID source register A
- id_rt_i  in  REG_AW  ID source register B
- id_use_rt_i  in  1  rt is a source operand (R-type, store, branch)
- id_rd_i  in  REG_AW  final destination after RegDst selection
- id_reg_write_i  in  1  ID instruction writes the register file
- id_mem_read_i  in  1  ID instruction is a load
- flush_i  in  1  squash the ID instruction (taken branch)
- fwd_a_sel_o  out  2  operand-A mux select for the EX instruction
- fwd_b_sel_o  out  2  operand-B mux select for the EX instruction
- stall_o  out  1  hold PC and IF/ID; insert a bubble into ID/EX
- stall_cnt_o  out  CNT_W  stall cycles (macro only)
- fwd_cnt_o  out  CNT_W  forwarded operands (macro only)

## Operation
- Tag = {valid, rd, mem_read}. The block holds three tags: T_EX, T_MEM, T_WB. A tag is valid only if the instruction writes the register file and its rd is not 0.
- Select codes: 0 = register-file value, 1 = EX/MEM ALU result, 2 = MEM/WB write-back value.
- Load-use hazard: T_EX.valid & T_EX.mem_read & id_valid_i & (id_rs_i==T_EX.rd | (id_use_rt_i & id_rt_i==T_EX.rd)).
- stall_o = hazard & ~flush_i. This output is combinational from the tags and the ID inputs.
- Every edge, T_MEM<=T_EX and T_WB<=T_MEM unconditionally. EX and later stages never stall.
- ID->EX loading:
  - flush_i, stall_o or ~id_valid_i: T_EX<=invalid and both selects<=0.
  - Otherwise T_EX<={id_reg_write_i & id_rd_i!=0, id_rd_i, id_mem_read_i}.
- Select computation for source s (rs for A; rt for B, and only if id_use_rt_i, else 0):
  - s!=0 & T_EX.valid & T_EX.rd==s -> 1 (the EX producer will be in MEM next cycle).
  - else s!=0 & T_MEM.valid & T_MEM.rd==s -> 2.
  - else 0.
  - The newest producer wins. Register 0 is never forwarded.
- After a one-cycle load stall, the load is in T_MEM, so the dependent operand gets select 2. Select 1 is never produced for a load producer.
- Flush and stall in the same cycle: flush wins. There is no stall, and a bubble enters EX.

## Timing
- Selects are registered and valid for the whole cycle the instruction occupies EX. Latency from ID inputs to select is 1 cycle.
- stall_o has zero latency and lasts exactly 1 cycle per load-use hazard. In the following cycle the producer is in MEM, so the hazard clears.
- Reset values: T_EX, T_MEM, T_WB all invalid; fwd_a_sel_o=fwd_b_sel_o=0; stall_o=0 (tags invalid); counters 0.
- Reset mid-operation discards all in-flight tags on the reset edge. The first ID instruction after reset gets selects of 0.

## Configuration
- FWD_HAZARD_CTRL_STATS_EN defined:
  - stall_cnt_o increments once for each cycle stall_o=1.
  - fwd_cnt_o increments by the number of nonzero selects loaded that edge (0, 1 or 2).
  - Both counters saturate at 2^CNT_W-1 and clear on rst_i.
- Macro undefined: the counter ports and logic are absent.

## Structure
- Package fwd_hazard_ctrl_pkg holds:
  - Select constants FWD_REG=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2.
  - The tag struct type and an invalid-tag constant.
- Sub-module fwd_tag_stage: one tag register with synchronous reset, load, and clear-to-bubble. It is instantiated three times.

## Test plan
- add $3 (I1) then sub uses rs=$3 in the next cycle -> fwd_a_sel_o=1 during the sub's EX cycle, no stall.
- add $3, nop, then or uses rt=$3 with id_use_rt_i=1 -> fwd_b_sel_o=2.
- lw $5 then add with rs=$5 -> stall_o=1 for exactly 1 cycle, bubble in EX, then fwd_a_sel_o=2.
- Two writers to $4 back-to-back, then a reader of $4 -> select 1 (newest wins). A writer to $0 followed by a reader of $0 -> select 0.
- Load-use hazard with flush_i=1 in the same cycle -> stall_o=0, next selects 0, T_EX invalid.
- rst_i asserted with three writers in flight -> all selects 0 and no stall for the next reader. With the macro defined, counters read 0, and forcing 2^16 stall cycles saturates stall_cnt_o at 0xFFFF.
